clk_period_meter: RTL
=====================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
- REQ-001: Parameter CNT_W, default 28, width of all count outputs; legal range 4..32.
- REQ-002: clk  input  1  system clock; all state updates on its rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: enable  input  1  measurement enable; level-sensitive.
- REQ-005: sig_in  input  1  slow clock or square wave under test; asynchronous to clk.
- REQ-006: period  output  CNT_W  clk cycles between two consecutive sig_in rising edges.
- REQ-007: high_time  output  CNT_W  clk cycles from a sig_in rising edge to the following falling edge.
- REQ-008: period_valid  output  1  one-cycle pulse, high in the cycle period/high_time update.
- REQ-009: overflow  output  1  sticky flag; the last measurement exceeded count range.

Function
- REQ-010: The block SHALL form an internal sample s of sig_in (see REQ-030/031) and a one-cycle-delayed copy s_d.
- REQ-011: rise = s & ~s_d and fall = ~s & s_d SHALL be combinational detects on those flops.
- REQ-012: The FSM SHALL have states IDLE, ARM and MEAS.
- REQ-013: IDLE -> ARM when enable=1; any state -> IDLE in the cycle after enable=0; enable=0 overrides a simultaneous edge.
- REQ-014: ARM: on rise, cnt <= 1 and hi_cap <= 0, then -> MEAS; no output change.
- REQ-015: MEAS: cnt SHALL increment by 1 per cycle.
- REQ-016: MEAS on fall: hi_cap <= cnt.
- REQ-017: MEAS on rise: period <= cnt, high_time <= hi_cap, period_valid <= 1, overflow <= 0, cnt <= 1, hi_cap <= 0; stay in MEAS.
- REQ-018: With a square wave of P clk cycles and H high cycles, steady-state outputs SHALL be period=P and high_time=H.
- REQ-019: The first valid pulse SHALL follow the second detected rise after leaving IDLE, never the first.
- REQ-020: If cnt equals 2^CNT_W-1 in MEAS without a rise: overflow <= 1, -> ARM, no valid pulse, period/high_time held.
- REQ-021: No fall between two rises SHALL give high_time=0.
- REQ-022: period and high_time SHALL hold their last values in IDLE and ARM.
- REQ-023: period_valid SHALL be 0 in every cycle other than those defined by REQ-017.
- REQ-024: Leaving IDLE SHALL NOT clear period, high_time or overflow.

Reset
- REQ-025: While rst=1, all sync flops, s_d, cnt and hi_cap SHALL be 0 and state SHALL be IDLE.
- REQ-026: While rst=1, period, high_time, period_valid and overflow SHALL be 0.
- REQ-027: Assertion SHALL take effect without a clk edge.
- REQ-028: rst asserted mid-MEAS SHALL discard the partial count; after release, a new measurement needs two fresh rises.
- REQ-029: The first state update after release SHALL occur on the first clk rising edge with rst=0.

Configuration
- REQ-030: Macro CLK_PERIOD_METER_SYNC_EN defined: s is sig_in through a two-flop synchronizer; period_valid rises on the 3rd clk edge after the sig_in rise that completes a period.
- REQ-031: Macro CLK_PERIOD_METER_SYNC_EN undefined: s is sig_in through one flop; that latency is 2 clk edges.
- REQ-032: Measured period and high_time values SHALL be identical in both builds.

Verification
- REQ-033: enable=1, sig_in period 10 clk, 4 high -> from the 2nd rise onward, period_valid once per 10 cycles with period=10 and high_time=4.
- REQ-034: CNT_W=8, one rise then sig_in held low -> overflow=1 after 255 counts, state ARM, no valid pulse, period unchanged.
- REQ-035: After REQ-034, restart sig_in with period 20 -> first valid pulse clears overflow and gives period=20.
- REQ-036: enable dropped while a rise is detected -> no valid pulse; state IDLE next cycle; outputs hold.
- REQ-037: rst pulsed mid-MEAS with period 10 -> all outputs 0 immediately; first valid pulse after the 2nd post-reset rise with period=10.
- REQ-038: Build with and without CLK_PERIOD_METER_SYNC_EN, same stimulus -> identical values; valid latency 3 vs 2 clk edges after the sig_in rise.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures sig_in period and high time in clk cycles, with a sticky overflow flag.
// Define CLK_PERIOD_METER_SYNC_EN for a two-flop input synchronizer (default: one flop).
module clk_period_meter #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state, state_nxt;
    logic s, s_d, rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hi_cap, hi_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic valid_nxt, ovf_nxt;

`ifdef CLK_PERIOD_METER_SYNC_EN
    logic s_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else begin
            s_meta <= sig_in;
            s      <= s_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= 1'b0;
        else     s <= sig_in;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_d <= 1'b0;
        else     s_d <= s;
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hi_cap       <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            hi_cap       <= hi_nxt;
            period       <= period_nxt;
            high_time    <= high_nxt;
            period_valid <= valid_nxt;
            overflow     <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi_cap;
        period_nxt = period;
        high_nxt   = high_time;
        valid_nxt  = 1'b0;
        ovf_nxt    = overflow;
        // Dropping enable wins over any edge seen in the same cycle.
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nxt = ARM;
                ARM: begin
                    if (rise) begin
                        cnt_nxt   = CNT_ONE;
                        hi_nxt    = '0;
                        state_nxt = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_nxt = cnt;
                        high_nxt   = hi_cap;
                        valid_nxt  = 1'b1;
                        ovf_nxt    = 1'b0;
                        cnt_nxt    = CNT_ONE;
                        hi_nxt     = '0;
                    end else if (cnt == CNT_MAX) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = ARM;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                        if (fall) hi_nxt = cnt;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
